// File: rtl/lab3_mem_pkg.sv
// Shared message layouts, request type encodings and response test codes
// for the line-granular memory responder.
package lab3_mem_pkg;

  typedef enum logic [2:0] {
    MEM_READ  = 3'd0,
    MEM_WRITE = 3'd1,
    MEM_INIT  = 3'd2
  } mem_type_e;

  typedef enum logic [1:0] {
    TEST_OK      = 2'b00,
    TEST_OOR     = 2'b01,
    TEST_BADTYPE = 2'b10
  } mem_test_e;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

  // An unknown type wins over an out-of-range address.
  function automatic mem_test_e resp_test(input logic [2:0] type_, input logic in_range);
    if (type_ != MEM_READ && type_ != MEM_WRITE && type_ != MEM_INIT)
      return TEST_BADTYPE;
    else if (!in_range)
      return TEST_OOR;
    else
      return TEST_OK;
  endfunction

endpackage

// File: rtl/lab3_mem_resp_queue.sv
// Response FIFO sitting between the fixed-latency delay line and the
// memory-side response port.
module lab3_mem_resp_queue
  import lab3_mem_pkg::*;
#(
  parameter int unsigned p_depth = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enq_val,
  input  mem_resp_16B_t                  enq_msg,
  output logic                           deq_val,
  input  logic                           deq_rdy,
  output mem_resp_16B_t                  deq_msg,
  output logic [$clog2(p_depth+1)-1:0]   count
);

  localparam int unsigned PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CW = $clog2(p_depth + 1);

  mem_resp_16B_t entries [p_depth];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          full;
  logic          do_enq;
  logic          do_deq;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full    = (cnt_q == CW'(p_depth));
    deq_val = (cnt_q != '0);
    do_deq  = deq_val & deq_rdy;
    do_enq  = enq_val & (~full | do_deq);
    deq_msg = deq_val ? entries[rd_ptr] : '0;
    count   = cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_enq) wr_ptr <= ptr_inc(wr_ptr);
      if (do_deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_enq, do_deq})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) entries[wr_ptr] <= enq_msg;
  end

endmodule

// File: rtl/lab3_mem_line_memory.sv
// Single-ported 128-bit line memory: array access at accept, fixed-latency
// delay line, then a response FIFO sized to absorb all outstanding requests.
module lab3_mem_line_memory
  import lab3_mem_pkg::*;
#(
  parameter int unsigned p_num_lines  = 64,
  parameter int unsigned p_latency    = 2,
  parameter int unsigned p_resp_depth = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memreq_val,
  output logic          memreq_rdy,
  input  mem_req_16B_t  memreq_msg,
  output logic          memresp_val,
  input  logic          memresp_rdy,
  output mem_resp_16B_t memresp_msg
);

  localparam int unsigned IW   = $clog2(p_num_lines);
  localparam int unsigned NSTG = p_latency - 1;
  localparam int unsigned OW   = $clog2(p_resp_depth + 1);

  logic [127:0]  lines [p_num_lines];
  logic          accept;
  logic          fire;
  logic [IW-1:0] idx;
  logic          in_range;
  logic          wr_en;
  mem_resp_16B_t resp_new;
  logic          tail_val;
  mem_resp_16B_t tail_msg;
  logic [OW-1:0] stg_cnt;
  logic [OW-1:0] q_count;
  logic [OW-1:0] o_now;
  logic [OW-1:0] o_next;
  logic          rdy_q;

  always_comb begin
    accept     = memreq_val & rdy_q;
    fire       = memresp_val & memresp_rdy;
    memreq_rdy = rdy_q;
    idx        = memreq_msg.addr[4 +: IW];
    in_range   = ((memreq_msg.addr >> (4 + IW)) == 32'd0);

    resp_new        = '0;
    resp_new.type_  = memreq_msg.type_;
    resp_new.opaque = memreq_msg.opaque;
    resp_new.len    = memreq_msg.len;
    resp_new.test   = resp_test(memreq_msg.type_, in_range);
    wr_en           = 1'b0;
    if (resp_new.test == TEST_OK) begin
      if (memreq_msg.type_ == MEM_READ) resp_new.data = lines[idx];
      else                              wr_en = accept;
    end
  end

  // Written at the accept edge, so a read accepted on the next cycle
  // already sees the new line.
  always_ff @(posedge clk) begin
    if (wr_en) lines[idx] <= memreq_msg.data;
  end

  // The accept edge itself is the first latency step, so only
  // p_latency-1 register stages sit before the FIFO.
  generate
    if (NSTG == 0) begin : g_direct
      always_comb begin
        tail_val = accept;
        tail_msg = resp_new;
        stg_cnt  = '0;
      end
    end else begin : g_delay
      logic [NSTG-1:0] v_q;
      mem_resp_16B_t   m_q [NSTG];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          v_q <= '0;
        end else begin
          v_q[0] <= accept;
          for (int unsigned i = 1; i < NSTG; i++) v_q[i] <= v_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        m_q[0] <= resp_new;
        for (int unsigned i = 1; i < NSTG; i++) m_q[i] <= m_q[i-1];
      end

      always_comb begin
        tail_val = v_q[NSTG-1];
        tail_msg = m_q[NSTG-1];
        stg_cnt  = '0;
        for (int unsigned i = 0; i < NSTG; i++) stg_cnt = stg_cnt + OW'(v_q[i]);
      end
    end
  endgenerate

  lab3_mem_resp_queue #(
    .p_depth (p_resp_depth)
  ) u_resp_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (tail_val),
    .enq_msg (tail_msg),
    .deq_val (memresp_val),
    .deq_rdy (memresp_rdy),
    .deq_msg (memresp_msg),
    .count   (q_count)
  );

  always_comb begin
    o_now  = stg_cnt + q_count;
    o_next = o_now;
    case ({accept, fire})
      2'b10:   o_next = o_now + OW'(1);
      2'b01:   o_next = o_now - OW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdy_q <= 1'b0;
    else        rdy_q <= (o_next < OW'(p_resp_depth));
  end

endmodule

// File: tb/tb_lab3_mem_line_memory.sv
// Directed bench: one instance at latency 3 / depth 4 for functional cases,
// one at latency 2 / depth 3 for streaming throughput.
module tb_lab3_mem_line_memory;
  import lab3_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic          a_req_val, a_req_rdy, a_resp_val, a_resp_rdy;
  mem_req_16B_t  a_req_msg;
  mem_resp_16B_t a_resp_msg;
  logic          b_req_val, b_req_rdy, b_resp_val, b_resp_rdy;
  mem_req_16B_t  b_req_msg;
  mem_resp_16B_t b_resp_msg;

  int n_cmp = 0;
  int n_err = 0;
  int n, stale, sent, got;

  localparam logic [127:0] V = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] W = 128'hCAFEF00D_0BADBEEF_13572468_FEDCBA98;

  lab3_mem_line_memory #(
    .p_num_lines  (64),
    .p_latency    (3),
    .p_resp_depth (4)
  ) dut_a (
    .clk         (clk),
    .reset       (rst_n),
    .memreq_val  (a_req_val),
    .memreq_rdy  (a_req_rdy),
    .memreq_msg  (a_req_msg),
    .memresp_val (a_resp_val),
    .memresp_rdy (a_resp_rdy),
    .memresp_msg (a_resp_msg)
  );

  lab3_mem_line_memory #(
    .p_num_lines  (64),
    .p_latency    (2),
    .p_resp_depth (3)
  ) dut_b (
    .clk         (clk),
    .reset       (rst_n),
    .memreq_val  (b_req_val),
    .memreq_rdy  (b_req_rdy),
    .memreq_msg  (b_req_msg),
    .memresp_val (b_resp_val),
    .memresp_rdy (b_resp_rdy),
    .memresp_msg (b_resp_msg)
  );

  always #5 clk = ~clk;

  function automatic mem_req_16B_t mk_req(input logic [2:0] t, input logic [7:0] op,
                                          input logic [31:0] addr, input logic [127:0] data);
    mem_req_16B_t r;
    r.type_  = t;
    r.opaque = op;
    r.addr   = addr;
    r.len    = 4'd0;
    r.data   = data;
    return r;
  endfunction

  function automatic logic [127:0] pat(input int j);
    return {4{32'hA5A50000 + 32'(j)}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp_a(input string tag, input logic [2:0] t, input logic [7:0] op,
                            input logic [1:0] te, input logic [127:0] da);
    chk({tag, "_val"},    128'(a_resp_val),        128'd1);
    chk({tag, "_type"},   128'(a_resp_msg.type_),  128'(t));
    chk({tag, "_opaque"}, 128'(a_resp_msg.opaque), 128'(op));
    chk({tag, "_test"},   128'(a_resp_msg.test),   128'(te));
    chk({tag, "_data"},   a_resp_msg.data,         da);
  endtask

  task automatic xact_a(input string tag, input mem_req_16B_t rq,
                        input logic [1:0] te, input logic [127:0] da);
    int cyc;
    chk({tag, "_rdy"}, 128'(a_req_rdy), 128'd1);
    a_req_msg = rq;
    a_req_val = 1'b1;
    @(negedge clk);
    a_req_val = 1'b0;
    cyc = 1;
    while (!a_resp_val && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 128'(cyc), 128'd3);
    chk_resp_a(tag, rq.type_, rq.opaque, te, da);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_req_val = 1'b0; a_req_msg = '0; a_resp_rdy = 1'b1;
    b_req_val = 1'b0; b_req_msg = '0; b_resp_rdy = 1'b1;
    #1;
    chk("rst_req_rdy",  128'(a_req_rdy),  128'd0);
    chk("rst_resp_val", 128'(a_resp_val), 128'd0);
    chk("rst_resp_msg", 128'(a_resp_msg), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 128'(a_req_rdy), 128'd1);

    // init line 3 then read it back
    a_req_val = 1'b1;
    a_req_msg = mk_req(3'd2, 8'h05, 32'h30, V);
    @(negedge clk);
    a_req_msg = mk_req(3'd0, 8'h06, 32'h30, '0);
    chk("t1_c1_val", 128'(a_resp_val), 128'd0);
    @(negedge clk);
    a_req_val = 1'b0;
    chk("t1_c2_val", 128'(a_resp_val), 128'd0);
    @(negedge clk);
    chk_resp_a("t1_init", 3'd2, 8'h05, 2'b00, '0);
    @(negedge clk);
    chk_resp_a("t1_read", 3'd0, 8'h06, 2'b00, V);
    @(negedge clk);
    chk("t1_idle", 128'(a_resp_val), 128'd0);

    // back-to-back write then read to 0x40
    a_req_val = 1'b1;
    a_req_msg = mk_req(3'd1, 8'h11, 32'h40, W);
    @(negedge clk);
    a_req_msg = mk_req(3'd0, 8'h12, 32'h40, '0);
    @(negedge clk);
    a_req_val = 1'b0;
    chk("t2_c2_val", 128'(a_resp_val), 128'd0);
    @(negedge clk);
    chk_resp_a("t2_write", 3'd1, 8'h11, 2'b00, '0);
    @(negedge clk);
    chk_resp_a("t2_read", 3'd0, 8'h12, 2'b00, W);
    @(negedge clk);
    chk("t2_idle", 128'(a_resp_val), 128'd0);

    // backpressure: only p_resp_depth requests get in
    a_resp_rdy = 1'b0;
    a_req_val  = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      a_req_msg = mk_req(3'd0, 8'(8'h20 + n), 32'h30, '0);
      if (a_req_rdy) n++;
      @(negedge clk);
    end
    chk("t3_accepts",  128'(n),          128'd4);
    chk("t3_rdy_low",  128'(a_req_rdy),  128'd0);
    a_req_val  = 1'b0;
    a_resp_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_resp_a($sformatf("t3_drain%0d", k), 3'd0, 8'(8'h20 + k), 2'b00, V);
      @(negedge clk);
    end
    chk("t3_empty",   128'(a_resp_val), 128'd0);
    chk("t3_rdy_up",  128'(a_req_rdy),  128'd1);

    // out-of-range and unknown type leave the array untouched
    xact_a("t4_oor_rd",  mk_req(3'd0, 8'h31, 32'h0000_1000, '0), 2'b01, '0);
    xact_a("t4_oor_wr",  mk_req(3'd1, 8'h32, 32'h0000_1030, '1), 2'b01, '0);
    xact_a("t4_badtype", mk_req(3'd3, 8'h33, 32'h30, '1),        2'b10, '0);
    xact_a("t4_check",   mk_req(3'd0, 8'h34, 32'h30, '0),        2'b00, V);
    @(negedge clk);

    // reset with three responses outstanding
    a_resp_rdy = 1'b0;
    a_req_val  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_req_msg = mk_req(3'd0, 8'(8'h40 + k), 32'h30, '0);
      @(negedge clk);
    end
    a_req_val = 1'b0;
    chk("t5_pre_val",    128'(a_resp_val),        128'd1);
    chk("t5_pre_opaque", 128'(a_resp_msg.opaque), 128'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_val", 128'(a_resp_val), 128'd0);
    chk("t5_rst_rdy", 128'(a_req_rdy),  128'd0);
    chk("t5_rst_msg", 128'(a_resp_msg), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_resp_rdy = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) chk("t5_rdy_after", 128'(a_req_rdy), 128'd1);
      if (a_resp_val) stale++;
    end
    chk("t5_stale", 128'(stale), 128'd0);
    xact_a("t5_kept", mk_req(3'd0, 8'h50, 32'h40, '0), 2'b00, W);

    // streaming: 16 writes then 16 reads, one response per cycle
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 36; cyc++) begin
      if (sent < 32) begin
        chk("s_rdy", 128'(b_req_rdy), 128'd1);
        b_req_val = 1'b1;
        if (sent < 16) b_req_msg = mk_req(3'd1, 8'(sent), 32'(sent) << 4, pat(sent));
        else           b_req_msg = mk_req(3'd0, 8'(sent), 32'(sent - 16) << 4, '0);
        if (b_req_rdy) sent++;
      end else begin
        b_req_val = 1'b0;
      end
      chk($sformatf("s_val_c%0d", cyc), 128'(b_resp_val), 128'(cyc >= 2 && cyc < 34));
      if (b_resp_val) begin
        chk($sformatf("s_opaque%0d", got), 128'(b_resp_msg.opaque), 128'(got));
        chk($sformatf("s_data%0d", got), b_resp_msg.data, (got < 16) ? 128'd0 : pat(got - 16));
        got++;
      end
      @(negedge clk);
    end
    chk("s_count", 128'(got), 128'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
